// File: rtl/dual_fetch_queue.sv
// Dual-issue fetch front end: fetches two sequential words per cycle into a small
// circular instruction queue and presents the oldest two entries to decode.
module dual_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [31:0]              imem_addr,
   input  logic                     imem_ready,
   input  logic [31:0]              imem_rdata1,
   input  logic [31:0]              imem_rdata2,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   input  logic [1:0]               consume,
   output logic [31:0]              pc_out,
   output logic [31:0]              instr1_out,
   output logic [31:0]              instr2_out,
   output logic                     valid1,
   output logic                     valid2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   ent_pc    [DEPTH];
   logic [31:0]   ent_instr [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] head_nxt1;
   logic [PW-1:0] tail_nxt1;
   logic [CW-1:0] cnt;
   logic [CW-1:0] pops;
   logic [31:0]   fetch_pc;
   logic          push;

   // Requests beyond the occupied count are clamped rather than flagged.
   always_comb begin
      pops = CW'(0);
      case (consume)
         2'd0:    pops = CW'(0);
         2'd1:    pops = CW'(1);
         default: pops = CW'(2);
      endcase
      if (pops > cnt) pops = cnt;
      push      = imem_ready && !redirect && (cnt <= CW'(DEPTH - 2));
      head_nxt1 = head + PW'(1);
      tail_nxt1 = tail + PW'(1);
   end

   always_comb begin
      imem_addr  = fetch_pc;
      count      = cnt;
      valid1     = (cnt != CW'(0));
      valid2     = (cnt >= CW'(2));
      pc_out     = valid1 ? ent_pc[head]         : 32'h0;
      instr1_out = valid1 ? ent_instr[head]      : 32'h0;
      instr2_out = valid2 ? ent_instr[head_nxt1] : 32'h0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_pc[i]    <= 32'h0;
            ent_instr[i] <= 32'h0;
         end
         head     <= '0;
         tail     <= '0;
         cnt      <= '0;
         fetch_pc <= RESET_PC;
      end else if (redirect) begin
         // Stale entries are left in place; count=0 makes them invisible.
         head     <= '0;
         tail     <= '0;
         cnt      <= '0;
         fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else begin
         if (push) begin
            ent_pc[tail]         <= fetch_pc;
            ent_instr[tail]      <= imem_rdata1;
            ent_pc[tail_nxt1]    <= fetch_pc + 32'd4;
            ent_instr[tail_nxt1] <= imem_rdata2;
            tail                 <= tail + PW'(2);
            fetch_pc             <= fetch_pc + 32'd8;
         end
         head <= head + pops[PW-1:0];
         cnt  <= cnt + (push ? CW'(2) : CW'(0)) - pops;
      end
   end

endmodule
